// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues one memory request at a time, buffers up to two returned
// instructions with their PCs, and flushes/refetches on redirect.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When defined, a redirect
// to a target that is not word aligned raises a sticky fetch_misalign flag
// and halts fetching until an aligned redirect or reset arrives. When left
// undefined, the low two target bits are simply dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        misalign_q, misalign_d;

  logic [31:0] target_pc;
  logic        target_misaligned;
  logic        issue;
  logic        push;
  logic        pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  // Keep the full target so a misaligned one can be flagged and held.
  always_comb begin
    target_pc         = redirect_pc;
    target_misaligned = (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_target_low;
  assign unused_target_low = ^redirect_pc[1:0];

  // Without the check, targets are forced onto a word boundary.
  always_comb begin
    target_pc         = {redirect_pc[31:2], 2'b00};
    target_misaligned = 1'b0;
  end
`endif

  // Request, push and pop qualifiers; redirect suppresses all of them.
  // The request is decoded from the current state rather than registered so
  // that a response can be followed by the next request one cycle later,
  // which is what gives one instruction every two cycles.
  always_comb begin
    issue = !rst && !redirect && !misalign_q &&
            (state_q == IDLE) && (count_q < 2'd2);
    push  = !redirect && (state_q == WAIT) && imem_rvalid;
    pop   = !redirect && (count_q != 2'd0) && instr_ready;
  end

  assign imem_req       = issue;
  assign imem_addr      = issue ? pc_q : 32'h0000_0000;
  assign instr_valid    = (count_q != 2'd0);
  assign instr          = buf_instr_q[rd_ptr_q];
  assign instr_pc       = buf_pc_q[rd_ptr_q];
  assign fetch_misalign = misalign_q;

  // Next-state logic for the FSM, PC, FIFO pointers and misalign flag.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    misalign_d  = misalign_q;

    if (redirect) begin
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      pc_d       = target_pc;
      misalign_d = target_misaligned;
      unique case (state_q)
        WAIT:    state_d = imem_rvalid ? IDLE : DROP;
        DROP:    state_d = imem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) state_d = IDLE;
        end
        DROP: begin
          if (imem_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (push) begin
        buf_instr_d[wr_ptr_q] = imem_rdata;
        buf_pc_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // FIFO storage; contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit. Inputs change on the falling
// edge and outputs are checked 1ns later; state advances on the rising edge.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  logic        rst2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_rvalid2;
  logic [31:0] imem_rdata2;
  logic        instr_valid2;
  logic        instr_ready2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        fetch_misalign2;

  int total;
  int bad;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fetch_misalign(fetch_misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .rst           (rst2),
    .imem_req      (imem_req2),
    .imem_addr     (imem_addr2),
    .imem_rvalid   (imem_rvalid2),
    .imem_rdata    (imem_rdata2),
    .instr_valid   (instr_valid2),
    .instr_ready   (instr_ready2),
    .instr         (instr2),
    .instr_pc      (instr_pc2),
    .redirect      (redirect2),
    .redirect_pc   (redirect_pc2),
    .fetch_misalign(fetch_misalign2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rd,
                               input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    rst         = r;
    imem_rvalid = rv;
    imem_rdata  = rd;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    instr_ready  = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    rst2         = 1'b1;
    imem_rvalid2 = 1'b0;
    imem_rdata2  = 32'h0;
    instr_ready2 = 1'b1;
    redirect2    = 1'b0;
    redirect_pc2 = 32'h0;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_misalign", {31'b0, fetch_misalign}, 32'd0);

    $display("[TB] streaming with ready high");
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("s0_req", {31'b0, imem_req}, 32'd1);
    checkOutput("s0_addr", imem_addr, 32'h0);
    applyStimulus(0, 1, 32'hA000_0000, 1, 0, 32'h0);
    checkOutput("s1_req", {31'b0, imem_req}, 32'd0);
    checkOutput("s1_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("s2_req", {31'b0, imem_req}, 32'd1);
    checkOutput("s2_addr", imem_addr, 32'h4);
    checkOutput("s2_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("s2_instr", instr, 32'hA000_0000);
    checkOutput("s2_pc", instr_pc, 32'h0);
    applyStimulus(0, 1, 32'hA000_0001, 1, 0, 32'h0);
    checkOutput("s3_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("s4_addr", imem_addr, 32'h8);
    checkOutput("s4_instr", instr, 32'hA000_0001);
    checkOutput("s4_pc", instr_pc, 32'h4);

    $display("[TB] backpressure");
    applyStimulus(0, 1, 32'hA000_0002, 0, 0, 32'h0);
    checkOutput("b0_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("b1_req", {31'b0, imem_req}, 32'd1);
    checkOutput("b1_addr", imem_addr, 32'hC);
    checkOutput("b1_instr", instr, 32'hA000_0002);
    applyStimulus(0, 1, 32'hA000_0003, 0, 0, 32'h0);
    checkOutput("b2_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("b3_full_req", {31'b0, imem_req}, 32'd0);
    checkOutput("b3_instr", instr, 32'hA000_0002);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("b4_full_req", {31'b0, imem_req}, 32'd0);
    checkOutput("b4_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("b4_instr", instr, 32'hA000_0002);
    checkOutput("b4_pc", instr_pc, 32'h8);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("b5_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("b6_req", {31'b0, imem_req}, 32'd1);
    checkOutput("b6_addr", imem_addr, 32'h10);
    checkOutput("b6_instr", instr, 32'hA000_0003);
    checkOutput("b6_pc", instr_pc, 32'hC);

    $display("[TB] redirect while waiting");
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0100);
    checkOutput("r0_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
    checkOutput("r1_req", {31'b0, imem_req}, 32'd0);
    checkOutput("r1_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("r2_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("r2_req", {31'b0, imem_req}, 32'd1);
    checkOutput("r2_addr", imem_addr, 32'h100);
    applyStimulus(0, 1, 32'hB000_0000, 0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("r4_addr", imem_addr, 32'h104);
    checkOutput("r4_instr", instr, 32'hB000_0000);
    checkOutput("r4_pc", instr_pc, 32'h100);

    $display("[TB] redirect with response and pop");
    applyStimulus(0, 1, 32'hB000_0001, 1, 1, 32'h0000_0300);
    checkOutput("c0_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("c1_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("c1_addr", imem_addr, 32'h300);
    applyStimulus(0, 1, 32'hC000_0000, 0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("c3_instr", instr, 32'hC000_0000);
    checkOutput("c3_pc", instr_pc, 32'h300);
    checkOutput("c3_addr", imem_addr, 32'h304);
    applyStimulus(0, 1, 32'hC000_0001, 0, 0, 32'h0);

    $display("[TB] misaligned redirect");
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0102);
    checkOutput("m0_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("m1_valid", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("m1_flag", {31'b0, fetch_misalign}, 32'd1);
    checkOutput("m1_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("m2_flag", {31'b0, fetch_misalign}, 32'd1);
    checkOutput("m2_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0200);
    checkOutput("m3_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("m4_flag", {31'b0, fetch_misalign}, 32'd0);
    checkOutput("m4_req", {31'b0, imem_req}, 32'd1);
    checkOutput("m4_addr", imem_addr, 32'h200);
`else
    checkOutput("m1_flag", {31'b0, fetch_misalign}, 32'd0);
    checkOutput("m1_req", {31'b0, imem_req}, 32'd1);
    checkOutput("m1_addr", imem_addr, 32'h100);
`endif

    $display("[TB] reset during outstanding request");
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("x0_req", {31'b0, imem_req}, 32'd0);
    checkOutput("x0_addr", imem_addr, 32'h0);
    applyStimulus(0, 1, 32'hEEEE_EEEE, 1, 0, 32'h0);
    checkOutput("x1_req", {31'b0, imem_req}, 32'd1);
    checkOutput("x1_addr", imem_addr, 32'h0);
    checkOutput("x1_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("x2_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(0, 1, 32'hF000_0000, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("x4_instr", instr, 32'hF000_0000);
    checkOutput("x4_pc", instr_pc, 32'h0);
    checkOutput("x4_addr", imem_addr, 32'h4);

    $display("[TB] PC wrap-around");
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    checkOutput("w0_req", {31'b0, imem_req2}, 32'd1);
    checkOutput("w0_addr", imem_addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_rvalid2 = 1'b1;
    imem_rdata2  = 32'h1111_1111;
    #1;
    checkOutput("w1_req", {31'b0, imem_req2}, 32'd0);
    @(negedge clk);
    imem_rvalid2 = 1'b0;
    #1;
    checkOutput("w2_req", {31'b0, imem_req2}, 32'd1);
    checkOutput("w2_addr", imem_addr2, 32'h0);
    checkOutput("w2_pc", instr_pc2, 32'hFFFF_FFFC);
    checkOutput("w2_instr", instr2, 32'h1111_1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
